// File: rtl/alu2_pkg.sv
// Shared types for the alu2 command issuer: opcode and FSM enums, and the queued command record.
package alu2_pkg;

   typedef enum logic [2:0] {
      OP_NOP = 3'd0,
      OP_ADC = 3'd1,
      OP_SUB = 3'd2,
      OP_ROL = 3'd3,
      OP_ROR = 3'd4,
      OP_AND = 3'd5,
      OP_ORR = 3'd6,
      OP_EOR = 3'd7
   } alu2_op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_ARM     = 3'd2,
      ST_STROBE  = 3'd3,
      ST_WAIT_LO = 3'd4,
      ST_WAIT_HI = 3'd5,
      ST_RESULT  = 3'd6
   } alu2_issue_state_e;

   // 21-bit command as held in the FIFO
   typedef struct packed {
      alu2_op_e    opcode;
      logic [7:0]  operand0;
      logic [7:0]  operand1;
      logic        carry;
      logic        chain;
   } alu2_cmd_t;

   function automatic alu2_cmd_t alu2_pack_cmd(input logic [2:0] opcode,
                                               input logic [7:0] operand0,
                                               input logic [7:0] operand1,
                                               input logic       carry,
                                               input logic       chain);
      alu2_cmd_t cmd;
      cmd.opcode   = alu2_op_e'(opcode);
      cmd.operand0 = operand0;
      cmd.operand1 = operand1;
      cmd.carry    = carry;
      cmd.chain    = chain;
      return cmd;
   endfunction

endpackage

// File: rtl/alu2_cmd_fifo.sv
// Synchronous FIFO of alu2 commands with full/empty/count; storage is not reset, pointers and count are.
module alu2_cmd_fifo
   import alu2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   push,
   input  alu2_cmd_t              wr_data,
   input  logic                   pop,
   output alu2_cmd_t              rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   alu2_cmd_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge aclk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/alu2_issue.sv
// Command issuer for the alu2 ALU: queues commands, runs write/strobe/busy per command, returns results.
// Build option ALU2_ISSUE_CARRY_CHAIN_EN adds a stored carry selectable per command via s_chain.
module alu2_issue
   import alu2_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [2:0] s_opcode,
   input  logic [7:0] s_operand0,
   input  logic [7:0] s_operand1,
   input  logic       s_carry,
   input  logic       s_chain,
   output logic       alu_enable,
   output logic       alu_write,
   output logic       alu_strobe,
   output logic [2:0] alu_opcode,
   output logic       alu_carryflag,
   output logic [7:0] alu_operand0,
   output logic [7:0] alu_operand1,
   input  logic [7:0] alu_result,
   input  logic       alu_carry,
   input  logic       alu_zero,
   input  logic       alu_sign,
   input  logic       alu_ready,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [7:0] m_result,
   output logic       m_carry,
   output logic       m_zero,
   output logic       m_sign,
   output logic       m_timeout
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   alu2_issue_state_e     state;
   alu2_issue_state_e     state_nxt;
   alu2_cmd_t             cmd_in;
   alu2_cmd_t             cmd_head;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                  load_cnt;
   logic [TMO_W-1:0]      tmo_cnt;
   logic                  tmo_last;
   logic                  cap_ok;
   logic                  cap_tmo;
   logic                  carry_sel;
   logic                  unused_sigs;

   assign cmd_in    = alu2_pack_cmd(s_opcode, s_operand0, s_operand1, s_carry, s_chain);
   assign s_ready   = !fifo_full;
   assign fifo_push = s_valid && s_ready;

   alu2_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .push    (fifo_push),
      .wr_data (cmd_in),
      .pop     (fifo_pop),
      .rd_data (cmd_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

`ifdef ALU2_ISSUE_CARRY_CHAIN_EN
   logic carry_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         carry_q <= 1'b0;
      end else if (cap_ok) begin
         carry_q <= alu_carry;
      end
   end

   assign carry_sel   = cmd_head.chain ? carry_q : cmd_head.carry;
   assign unused_sigs = ^fifo_count;
`else
   assign carry_sel   = cmd_head.carry;
   assign unused_sigs = ^{fifo_count, cmd_head.chain};
`endif

   // wait budget spans WAIT_LO and WAIT_HI together; abandon on the TIMEOUT-th wait cycle
   assign tmo_last = (tmo_cnt >= TMO_W'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      cap_ok    = 1'b0;
      cap_tmo   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty && alu_enable) begin
               fifo_pop  = 1'b1;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (load_cnt) begin
               state_nxt = ST_ARM;
            end
         end
         ST_ARM:    state_nxt = ST_STROBE;
         ST_STROBE: state_nxt = ST_WAIT_LO;
         ST_WAIT_LO: begin
            if (tmo_last) begin
               cap_tmo   = 1'b1;
               state_nxt = ST_RESULT;
            end else if (!alu_ready) begin
               state_nxt = ST_WAIT_HI;
            end
         end
         ST_WAIT_HI: begin
            if (alu_ready) begin
               cap_ok    = 1'b1;
               state_nxt = ST_RESULT;
            end else if (tmo_last) begin
               cap_tmo   = 1'b1;
               state_nxt = ST_RESULT;
            end
         end
         ST_RESULT: begin
            if (m_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // control registers; ALU strobes and m_valid follow the next state so they are glitch-free
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= ST_IDLE;
         load_cnt   <= 1'b0;
         tmo_cnt    <= '0;
         alu_enable <= 1'b0;
         alu_write  <= 1'b0;
         alu_strobe <= 1'b0;
         m_valid    <= 1'b0;
      end else begin
         state      <= state_nxt;
         alu_enable <= 1'b1;
         alu_write  <= (state_nxt == ST_LOAD);
         alu_strobe <= (state_nxt == ST_STROBE);
         m_valid    <= (state_nxt == ST_RESULT);
         load_cnt   <= (state == ST_LOAD) && !load_cnt;
         if ((state == ST_WAIT_LO) || (state == ST_WAIT_HI)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end else begin
            tmo_cnt <= '0;
         end
      end
   end

   // command registers toward the ALU, loaded at pop
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         alu_opcode    <= 3'd0;
         alu_carryflag <= 1'b0;
         alu_operand0  <= 8'd0;
         alu_operand1  <= 8'd0;
      end else if (fifo_pop) begin
         alu_opcode    <= cmd_head.opcode;
         alu_carryflag <= carry_sel;
         alu_operand0  <= cmd_head.operand0;
         alu_operand1  <= cmd_head.operand1;
      end
   end

   // result registers only change at capture, so they hold while m_valid is up
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_result  <= 8'd0;
         m_carry   <= 1'b0;
         m_zero    <= 1'b0;
         m_sign    <= 1'b0;
         m_timeout <= 1'b0;
      end else if (cap_ok) begin
         m_result  <= alu_result;
         m_carry   <= alu_carry;
         m_zero    <= alu_zero;
         m_sign    <= alu_sign;
         m_timeout <= 1'b0;
      end else if (cap_tmo) begin
         m_result  <= 8'd0;
         m_carry   <= 1'b0;
         m_zero    <= 1'b0;
         m_sign    <= 1'b0;
         m_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu2_issue.sv
// Self-checking bench for alu2_issue: vector table, scoreboard monitor and multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_alu2_issue;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic       s_valid, s_ready, s_carry, s_chain;
   logic [2:0] s_opcode;
   logic [7:0] s_operand0, s_operand1;
   logic       alu_enable, alu_write, alu_strobe, alu_carryflag;
   logic [2:0] alu_opcode;
   logic [7:0] alu_operand0, alu_operand1;
   logic [7:0] alu_result;
   logic       alu_carry, alu_zero, alu_sign, alu_ready;
   logic       m_valid, m_ready, m_carry, m_zero, m_sign, m_timeout;
   logic [7:0] m_result;

   int checks = 0;
   int errors = 0;
   logic [11:0] sb [$];

   alu2_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_valid(s_valid), .s_ready(s_ready), .s_opcode(s_opcode),
      .s_operand0(s_operand0), .s_operand1(s_operand1), .s_carry(s_carry), .s_chain(s_chain),
      .alu_enable(alu_enable), .alu_write(alu_write), .alu_strobe(alu_strobe),
      .alu_opcode(alu_opcode), .alu_carryflag(alu_carryflag),
      .alu_operand0(alu_operand0), .alu_operand1(alu_operand1),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .alu_sign(alu_sign), .alu_ready(alu_ready),
      .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
      .m_carry(m_carry), .m_zero(m_zero), .m_sign(m_sign), .m_timeout(m_timeout)
   );

   always #5 aclk = ~aclk;

   // ALU behavioural model: {carry, result}
   function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                         input logic c);
      case (op)
         3'd1:    return {1'b0, a} + {1'b0, b} + {8'd0, c};
         3'd2:    return {1'b0, a} + {1'b0, ~b} + {8'd0, c};
         3'd3:    return {a[7], a[6:0], c};
         3'd4:    return {a[0], c, a[7:1]};
         3'd5:    return {c, a & b};
         3'd6:    return {c, a | b};
         3'd7:    return {c, a ^ b};
         default: return {c, a};
      endcase
   endfunction

   logic [2:0] op_q;
   logic [7:0] a_q, b_q;
   logic       c_q, strb_q;
   logic       alu_stuck = 1'b0;
   logic [8:0] r9;
   int         busy;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         alu_ready <= 1'b1; alu_result <= 8'd0; alu_carry <= 1'b0; alu_zero <= 1'b0; alu_sign <= 1'b0;
         strb_q <= 1'b0; busy <= 0; op_q <= 3'd0; a_q <= 8'd0; b_q <= 8'd0; c_q <= 1'b0;
      end else begin
         strb_q <= alu_strobe;
         if (alu_write) begin
            op_q <= alu_opcode; a_q <= alu_operand0; b_q <= alu_operand1; c_q <= alu_carryflag;
         end
         if (busy != 0) begin
            busy <= busy - 1;
            if (busy == 1) begin
               r9 = alu_fn(op_q, a_q, b_q, c_q);
               alu_ready  <= 1'b1;
               alu_result <= r9[7:0];
               alu_carry  <= r9[8];
               alu_zero   <= (r9[7:0] == 8'd0);
               alu_sign   <= r9[7];
            end
         end else if (strb_q && !alu_stuck) begin
            alu_ready <= 1'b0;
            busy      <= 4;
         end
      end
   end

   // scoreboard monitor: compares at each handshake, checks stability under back-pressure
   logic        prev_v = 1'b0, prev_hs = 1'b0, hs;
   logic [11:0] prev_d, cur, e;

   always @(negedge aclk) begin
      if (!aresetn) begin
         prev_v = 1'b0;
      end else begin
         cur = {m_result, m_carry, m_zero, m_sign, m_timeout};
         if (prev_v && !prev_hs) begin
            checks++;
            if (!m_valid || cur !== prev_d) begin
               errors++;
               $display("FAIL m_stable actual v=%0b d=%h required v=1 d=%h", m_valid, cur, prev_d);
            end
         end
         hs = m_valid && m_ready;
         if (hs) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL m_unexpected actual=%h required=no result", cur);
            end else begin
               e = sb.pop_front();
               if (cur !== e) begin
                  errors++;
                  $display("FAIL m_result actual={r,c,z,s,t}=%h required=%h", cur, e);
               end
            end
         end
         prev_v = m_valid; prev_hs = hs; prev_d = cur;
      end
   end

   function automatic logic [11:0] mk(input logic [7:0] r, input logic c, input logic z, input logic s,
                                      input logic t);
      return {r, c, z, s, t};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic ch, input logic [11:0] exp_d);
      int n = 0;
      s_valid = 1'b1; s_opcode = op; s_operand0 = a; s_operand1 = b; s_carry = c; s_chain = ch;
      while (!s_ready && n < 200) begin
         @(posedge aclk); #1; n++;
      end
      if (!s_ready) begin
         chk("push_accept", 0, 1);
         s_valid = 1'b0;
      end else begin
         @(posedge aclk);
         sb.push_back(exp_d);
         #1 s_valid = 1'b0;
      end
   endtask

   task automatic wait_mvalid(input string name);
      int n = 0;
      while (!m_valid && n < 200) begin
         @(posedge aclk); #1; n++;
      end
      chk(name, m_valid, 1);
   endtask

   task automatic drain(input bit rnd);
      int n = 0;
      while ((sb.size() != 0 || m_valid) && n < 1000) begin
         m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge aclk); #1; n++;
      end
      m_ready = 1'b1;
      chk("drain", sb.size(), 0);
   endtask

   function automatic logic [35:0] all_outs();
      return {alu_enable, alu_write, alu_strobe, alu_opcode, alu_carryflag, alu_operand0, alu_operand1,
              m_valid, m_result, m_carry, m_zero, m_sign, m_timeout};
   endfunction

   typedef struct {
      logic [2:0] op;
      logic [7:0] a, b;
      logic       cin;
      logic [7:0] r;
      logic       c, z, s;
   } vec_t;

   vec_t        vecs [9];
   logic [19:0] wv, sv, mv;
   logic        saw;

   initial begin
      vecs[0] = '{3'd1, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{3'd2, 8'h50, 8'h20, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{3'd2, 8'h20, 8'h50, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{3'd3, 8'h81, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{3'd4, 8'h01, 8'h00, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{3'd5, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{3'd6, 8'hA0, 8'h05, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{3'd7, 8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{3'd0, 8'h3C, 8'h99, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};

      s_valid = 1'b0; s_opcode = 3'd0; s_operand0 = 8'd0; s_operand1 = 8'd0; s_carry = 1'b0; s_chain = 1'b0;
      m_ready = 1'b1;

      #1;
      chk("reset_outs", all_outs(), 0);
      chk("reset_count", dut.u_fifo.count, 0);
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
      chk("enable_before_edge", alu_enable, 0);
      @(posedge aclk); #1;
      chk("enable_after_edge", alu_enable, 1);

      // single ADC with cycle-accurate protocol timing
      push(3'd1, 8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b0, 1'b1, 1'b0));
      for (int k = 1; k <= 20; k++) begin
         @(posedge aclk); #1;
         wv[k-1] = alu_write; sv[k-1] = alu_strobe; mv[k-1] = m_valid;
      end
      chk("write_window", wv, 20'h00003);
      chk("strobe_window", sv, 20'h00008);
      chk("mvalid_window", mv, 20'h00400);
      drain(1'b0);

      for (int i = 0; i < 9; i++) begin
         push(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
              mk(vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].s, 1'b0));
      end
      drain(1'b0);

      // 16-bit add across two commands
      push(3'd1, 8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
`ifdef ALU2_ISSUE_CARRY_CHAIN_EN
      push(3'd1, 8'h00, 8'h00, 1'b0, 1'b1, mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
`else
      push(3'd1, 8'h00, 8'h00, 1'b0, 1'b1, mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
`endif
      drain(1'b0);

      // fill the FIFO behind a stalled result, then drain with random back-pressure
      m_ready = 1'b0;
      push(3'd6, 8'h01, 8'h10, 1'b0, 1'b0, mk(8'h11, 1'b0, 1'b0, 1'b0, 1'b0));
      wait_mvalid("fill_head_result");
      for (int i = 0; i < DEPTH; i++) begin
         push(3'd1, 8'(i * 16), 8'h01, 1'b0, 1'b0, mk(8'(i * 16 + 1), 1'b0, 1'b0, 1'b0, 1'b0));
      end
      chk("fill_s_ready", s_ready, 0);
      chk("fill_count", dut.u_fifo.count, DEPTH);
      drain(1'b1);

      // push and pop on the same edge with DEPTH-1 entries queued
      m_ready = 1'b0;
      push(3'd7, 8'h55, 8'hFF, 1'b0, 1'b0, mk(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0));
      wait_mvalid("same_edge_head");
      for (int i = 0; i < DEPTH - 1; i++) begin
         push(3'd5, 8'hFF, 8'(8'h11 << i), 1'b1, 1'b0, mk(8'(8'h11 << i), 1'b1, 1'b0, 1'(i == 3), 1'b0));
      end
      chk("same_edge_pre_count", dut.u_fifo.count, DEPTH - 1);
      m_ready = 1'b1;
      @(posedge aclk); #1;
      push(3'd0, 8'h80, 8'h00, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b0, 1'b1, 1'b0));
      chk("same_edge_count", dut.u_fifo.count, DEPTH - 1);
      chk("same_edge_s_ready", s_ready, 1);
      drain(1'b0);

      // ALU never goes busy: command is abandoned, the next one runs normally
      alu_stuck = 1'b1;
      push(3'd1, 8'h01, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
      drain(1'b0);
      alu_stuck = 1'b0;
      push(3'd6, 8'h0F, 8'h30, 1'b0, 1'b0, mk(8'h3F, 1'b0, 1'b0, 1'b0, 1'b0));
      drain(1'b0);

      // reset during WAIT_HI with two commands still queued
      push(3'd1, 8'h01, 8'h02, 1'b0, 1'b0, 12'h000);
      push(3'd1, 8'h03, 8'h04, 1'b0, 1'b0, 12'h000);
      push(3'd1, 8'h05, 8'h06, 1'b0, 1'b0, 12'h000);
      begin
         int n = 0;
         while (alu_ready && n < 200) begin
            @(posedge aclk); #1; n++;
         end
         chk("alu_busy_seen", alu_ready, 0);
      end
      @(posedge aclk); #1;
      aresetn = 1'b0;
      #1;
      chk("midop_reset_outs", all_outs(), 0);
      chk("midop_reset_count", dut.u_fifo.count, 0);
      sb.delete();
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      chk("rerelease_enable_before", alu_enable, 0);
      @(posedge aclk); #1;
      chk("rerelease_enable_after", alu_enable, 1);
      saw = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(posedge aclk); #1;
         saw = saw | m_valid | alu_write;
      end
      chk("no_spurious_activity", saw, 0);
      push(3'd5, 8'hFF, 8'h81, 1'b0, 1'b0, mk(8'h81, 1'b0, 1'b0, 1'b1, 1'b0));
      drain(1'b0);

      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
